// File: rtl/ign_sched_bank.sv
// Bank of NCH angle-domain ignition channels sharing one sub-tooth angle interpolator.
// Optional over-dwell watchdog is enabled by defining IGN_OVERDWELL_EN.
module ign_sched_bank #(
  parameter int NCH           = 4,
  parameter int AW            = 16,
  parameter int PW            = 32,
  parameter int MAX_DWELL_CYC = 24000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              synced,
  input  logic              trigger,
  input  logic [AW-1:0]     eng_phase,
  input  logic [PW-1:0]     tooth_period,
  input  logic [AW-1:0]     quanta_per_rev,
  input  logic [NCH*AW-1:0] ign_phase,
  input  logic [AW-1:0]     ign_timing,
  input  logic [AW-1:0]     dwell,
  input  logic [NCH-1:0]    en,
  input  logic [1:0]        mode,
  input  logic              fault_clr,
  output logic [NCH-1:0]    ign,
  output logic [NCH-1:0]    overdwell,
  output logic [AW-1:0]     angle
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DWELL = 1'b1;
  localparam logic [PW:0] TOOTH_Q = (PW+1)'(256);

  function automatic logic [AW-1:0] mod_sub(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                            input logic [AW-1:0] m);
    return (a >= b) ? (a - b) : (a - b + m);
  endfunction

  // Target t lies in (p, c] on the circle; no movement means no crossing.
  function automatic logic crossed(input logic [AW-1:0] t, input logic [AW-1:0] p,
                                   input logic [AW-1:0] c);
    if (p == c)     return 1'b0;
    else if (p < c) return (t > p) && (t <= c);
    else            return (t > p) || (t <= c);
  endfunction

  // Reset asserts immediately but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n_s;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_s = rst_sync_q[1];

  logic [AW-1:0] base_q, angle_q, angle_d, prev_q;
  logic [7:0]    sub_q, sub_d;
  logic [PW:0]   acc_q, acc_d;
  logic [PW-1:0] period_q;
  logic [AW:0]   sum_s;

  always_comb begin
    acc_d = acc_q;
    sub_d = sub_q;
    if (trigger) begin
      acc_d = '0;
      sub_d = 8'd0;
    end else if ((period_q != '0) && (sub_q != 8'd255)) begin
      if ((acc_q + TOOTH_Q) >= {1'b0, period_q}) begin
        acc_d = acc_q + TOOTH_Q - {1'b0, period_q};
        sub_d = sub_q + 8'd1;
      end else begin
        acc_d = acc_q + TOOTH_Q;
      end
    end else begin
      acc_d = acc_q;
    end
    sum_s   = trigger ? {1'b0, eng_phase} : ({1'b0, base_q} + (AW+1)'(sub_d));
    angle_d = (sum_s >= {1'b0, quanta_per_rev}) ? AW'(sum_s - {1'b0, quanta_per_rev})
                                                 : sum_s[AW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      base_q <= '0; angle_q <= '0; prev_q <= '0;
      sub_q <= 8'd0; acc_q <= '0; period_q <= '0;
    end else begin
      if (trigger) begin
        base_q   <= eng_phase;
        period_q <= tooth_period;
      end else begin
        base_q   <= base_q;
        period_q <= period_q;
      end
      sub_q   <= sub_d;
      acc_q   <= acc_d;
      angle_q <= angle_d;
      prev_q  <= angle_q;
    end
  end

  logic [AW-1:0]  dw_s;
  logic [AW-1:0]  fire_q [NCH];
  logic [AW-1:0]  start_q [NCH];
  logic [AW-1:0]  fire_d [NCH];
  logic [AW-1:0]  start_d [NCH];
  logic [NCH-1:0] valid_q, valid_d;

  assign dw_s = (dwell >= quanta_per_rev) ? (quanta_per_rev - AW'(1)) : dwell;

  always_comb begin
    fire_d  = '{default: '0};
    start_d = '{default: '0};
    valid_d = '0;
    for (int i = 0; i < NCH; i++) begin
      fire_d[i]  = mod_sub(ign_phase[i*AW +: AW], ign_timing, quanta_per_rev);
      start_d[i] = mod_sub(fire_d[i], dw_s, quanta_per_rev);
      valid_d[i] = ign_phase[i*AW +: AW] < quanta_per_rev;
    end
  end

  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      for (int i = 0; i < NCH; i++) begin
        fire_q[i]  <= '0;
        start_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      fire_q  <= fire_d;
      start_q <= start_d;
      valid_q <= valid_d;
    end
  end

  logic [NCH-1:0] start_x_s, fire_x_s, arm_ok_s, over_s, block_s;
  logic [NCH-1:0] st_q, st_d, ign_q, ign_d;

  always_comb begin
    start_x_s = '0;
    fire_x_s  = '0;
    arm_ok_s  = '0;
    for (int i = 0; i < NCH; i++) begin
      start_x_s[i] = crossed(start_q[i], prev_q, angle_q);
      fire_x_s[i]  = crossed(fire_q[i], prev_q, angle_q);
      arm_ok_s[i]  = synced & en[i] & (mode != 2'd3) & valid_q[i];
    end
  end

`ifdef IGN_OVERDWELL_EN
  localparam int CW = $clog2(MAX_DWELL_CYC + 1);
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic [NCH-1:0] od_q, od_d;

  // Counter runs only while dwelling, so it is zero on every DWELL entry.
  always_comb begin
    cnt_d  = cnt_q;
    over_s = '0;
    od_d   = od_q;
    for (int i = 0; i < NCH; i++) begin
      if (st_q[i] == ST_DWELL) begin
        over_s[i] = cnt_q[i] >= CW'(MAX_DWELL_CYC - 1);
        cnt_d[i]  = cnt_q[i] + CW'(1);
      end else begin
        cnt_d[i]  = '0;
      end
      od_d[i] = fault_clr ? 1'b0 : (od_q[i] | over_s[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      od_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      od_q  <= od_d;
    end
  end

  assign block_s   = od_q;
  assign overdwell = od_q;
`else
  logic unused_cfg_s;
  assign unused_cfg_s = fault_clr | (MAX_DWELL_CYC < 1);
  assign over_s       = '0;
  assign block_s      = '0;
  assign overdwell    = '0;
`endif

  always_comb begin
    st_d = st_q;
    for (int i = 0; i < NCH; i++) begin
      case (st_q[i])
        ST_IDLE: begin
          if (arm_ok_s[i] && start_x_s[i] && !fire_x_s[i] && !block_s[i]) st_d[i] = ST_DWELL;
          else st_d[i] = ST_IDLE;
        end
        ST_DWELL: begin
          if (!arm_ok_s[i] || fire_x_s[i] || over_s[i]) st_d[i] = ST_IDLE;
          else st_d[i] = ST_DWELL;
        end
        default: st_d[i] = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ign_d = '0;
    case (mode)
      2'd0: ign_d = st_q;
      2'd1: begin
        for (int i = 0; i < NCH/2; i++) ign_d[i] = st_q[i] | st_q[i + NCH/2];
      end
      2'd2: ign_d[0] = |st_q;
      default: ign_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      st_q  <= '0;
      ign_q <= '0;
    end else begin
      st_q  <= st_d;
      ign_q <= ign_d;
    end
  end

  assign ign   = ign_q;
  assign angle = angle_q;

endmodule
